ps2_scan_buffer: RTL and testbench
==================================

// Module: ps2_scan_buffer
// PURPOSE
// - Parametrised PS/2 keyboard receiver: deserialises PS/2 frames, decodes E0/F0 prefixes, buffers key events in a FIFO.
// - Presents the FIFO head to the CPU data path as a show-ahead entry with a pop strobe.
// - Sits beside Data_Memory on the CPU bus. Supersedes the single-register key capture, which lost keys, had no break or extended decode, and no error reporting.
// PARAMETERS
// - FIFO_DEPTH      8      entries; power of two, >=2
// - SYNC_STAGES     2      flops in the ps2_clk/ps2_data synchronisers, >=2
// - FILTER_BREAK    1      1: key releases (F0 xx) are discarded; 0: releases are queued with key_break=1
// - TIMEOUT_CYCLES  50000  clk cycles with no ps2_clk fall inside a frame before the frame is aborted
// PORTS
// - clk         in   1                       system clock; all state on rising edge
// - rst         in   1                       asynchronous, active-low reset
// - ps2_clk     in   1                       raw PS/2 clock, asynchronous
// - ps2_data    in   1                       raw PS/2 data, asynchronous
// - pop         in   1                       removes the head entry; ignored when key_valid=0
// - clr_err     in   1                       clears overflow and frame_err
// - key_valid   out  1                       FIFO not empty
// - key_code    out  8                       head scan code (show-ahead)
// - key_ext     out  1                       head entry was E0-prefixed
// - key_break   out  1                       head entry is a release
// - fifo_count  out  $clog2(FIFO_DEPTH)+1    number of entries held
// - overflow    out  1                       sticky: an event was dropped because the FIFO was full
// - frame_err   out  1                       sticky: bad start, parity or stop bit, or timeout
// BEHAVIOUR
// - Reset (rst=0, async): FIFO empty, FSM in IDLE, prefix flags clear. All outputs are 0.
// - Input path: ps2_clk and ps2_data pass through SYNC_STAGES flops. A falling edge of synced ps2_clk gives a 1-cycle fall pulse; each bit is sampled on that pulse.
// - Frame FSM, 11 bits. IDLE->DATA only when the start bit is 0; a start bit of 1 keeps IDLE and sets frame_err.
//   - DATA: 8 bits, LSB first, counted 0..7. Then PARITY (odd parity over data+parity), then STOP (must be 1).
//   - Bad parity or stop bit: byte discarded, frame_err=1, return to IDLE.
// - Timeout: outside IDLE, a counter counts cycles since the last fall pulse. At TIMEOUT_CYCLES it aborts to IDLE and sets frame_err.
// - Decoder, applied to each good byte:
//   - 8'hE0 sets ext_pend; 8'hF0 sets brk_pend.
//   - Any other byte forms entry {ext_pend,brk_pend,byte} and clears both flags.
//   - If FILTER_BREAK=1 and brk_pend=1, the entry is dropped; flags still clear.
// - Latency: key_valid rises exactly 2 clk cycles after the fall pulse that samples a valid stop bit (1 cycle decode, 1 cycle FIFO write).
// - FIFO: push when full drops the entry and sets overflow=1. Push and pop in the same cycle when full: both accepted, overflow unchanged. Push and pop in the same cycle when empty: the push lands and key_valid rises next cycle. Pointers wrap modulo FIFO_DEPTH.
// - pop: head advances next cycle; fifo_count updates in the same edge.
// - clr_err and a new error in the same cycle: the error wins (flag stays 1).
// - Reset mid-frame: partial byte and pending prefixes discarded; the next frame is decoded normally.
// STRUCTURE
// - Package ps2_pkg holds:
//   - rx_state_e {IDLE,DATA,PARITY,STOP}
//   - localparams PS2_EXT=8'hE0, PS2_BRK=8'hF0
//   - packed struct key_evt_t {ext,brk,code[7:0]}
// - Sub-module ps2_scan_fifo: synchronous FIFO of key_evt_t with show-ahead read, full/empty and count.
// - Synchroniser, edge detect, frame FSM, timeout counter and decoder live in this module.
// TESTING
// - Send 8'h1C (start 0, odd parity 0, stop 1) -> key_valid=1 two cycles after stop fall pulse, key_code=1C, ext=0, brk=0, count=1.
// - FILTER_BREAK=0, send E0,F0,75 -> one entry: code=75, ext=1, brk=1. FILTER_BREAK=1, same bytes -> FIFO stays empty.
// - Send 1C with parity bit flipped -> no entry, frame_err=1. Pulse clr_err -> frame_err=0.
// - Send 9 codes, no pops, DEPTH=8 -> count=8, overflow=1, head=first code. Pop 8 times -> codes in order, then key_valid=0.
// - Stop ps2_clk after 4 data bits, wait TIMEOUT_CYCLES -> frame_err=1. Next full frame 29 -> entry 29.
// - Hold DEPTH=8 full, push and pop in the same cycle -> count stays 8, overflow unchanged. Assert rst low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver and its event FIFO.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_evt_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_scan_fifo.sv
// Synchronous show-ahead FIFO of key events. A push into a full FIFO is only
// accepted when a pop frees a slot in the same cycle; otherwise it is dropped
// and reported on the drop strobe.
module ps2_scan_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  key_evt_t                    push_evt,
    input  logic                        pop,
    output key_evt_t                    head_evt,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        drop
);

    localparam int AW = $clog2(FIFO_DEPTH);

    key_evt_t          mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic              full;
    logic              do_pop;
    logic              do_push;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (AW+1)'(FIFO_DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign drop     = push & full & ~do_pop;
    assign head_evt = mem[rd_ptr];
    assign count    = cnt;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_evt;
    end

endmodule

// File: rtl/ps2_scan_buffer.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, deserialises 11-bit
// frames, folds E0/F0 prefixes into key events and queues them in a FIFO whose
// head is presented show-ahead to the CPU bus.
module ps2_scan_buffer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_BREAK   = 1,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    input  logic                        pop,
    input  logic                        clr_err,
    output logic                        key_valid,
    output logic [7:0]                  key_code,
    output logic                        key_ext,
    output logic                        key_break,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic                        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   bit_in;

    rx_state_e              state;
    rx_state_e              state_nx;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_reg;
    logic                   par_bit;
    logic [TW-1:0]          to_cnt;
    logic                   timeout_hit;
    logic                   frame_bad;
    logic                   byte_good;

    logic [7:0]             byte_p0;
    logic                   vld_p0;

    logic                   ext_pend;
    logic                   brk_pend;
    logic                   is_ext;
    logic                   is_brk;
    logic                   push;
    key_evt_t               push_evt;

    key_evt_t               head_evt;
    logic                   fifo_empty;
    logic                   fifo_drop;

    // Synchronisers idle high so that reset release never fakes a clock fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in = data_sync[SYNC_STAGES-1];

    assign timeout_hit = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Frame state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic; a byte is accepted only with odd parity and a high stop bit.
    always_comb begin
        state_nx  = state;
        frame_bad = 1'b0;
        byte_good = 1'b0;
        if (timeout_hit) begin
            state_nx  = IDLE;
            frame_bad = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!bit_in) state_nx = DATA;
                    else         frame_bad = 1'b1;
                end
                DATA: begin
                    if (bit_cnt == 3'd7) state_nx = PARITY;
                end
                PARITY: state_nx = STOP;
                STOP: begin
                    state_nx = IDLE;
                    if (bit_in && odd_parity_ok(shift_reg, par_bit)) byte_good = 1'b1;
                    else                                            frame_bad = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Bit counter restarts on every start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
        end else if (fall) begin
            if (state == IDLE)      bit_cnt <= '0;
            else if (state == DATA) bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Deserialiser: LSB arrives first, so bits shift in from the top.
    always_ff @(posedge clk) begin
        if (fall && state == DATA)   shift_reg <= {bit_in, shift_reg[7:1]};
        if (fall && state == PARITY) par_bit   <= bit_in;
    end

    // Inactivity watchdog, cleared by every sampled bit and idle while no frame is open.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               to_cnt <= '0;
        else if (state == IDLE || fall)         to_cnt <= '0;
        else if (timeout_hit)                   to_cnt <= '0;
        else                                    to_cnt <= to_cnt + 1'b1;
    end

    // ---- stage p0: completed byte ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_p0 <= 1'b0;
        else      vld_p0 <= byte_good;
    end

    // Byte capture carries data only.
    always_ff @(posedge clk) begin
        if (byte_good) byte_p0 <= shift_reg;
    end

    assign is_ext   = (byte_p0 == PS2_EXT);
    assign is_brk   = (byte_p0 == PS2_BRK);
    assign push     = vld_p0 && !is_ext && !is_brk && !((FILTER_BREAK != 0) && brk_pend);
    assign push_evt = '{ext: ext_pend, brk: brk_pend, code: byte_p0};

    // Prefix flags accumulate until a non-prefix byte consumes them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (vld_p0) begin
            if (is_ext) begin
                ext_pend <= 1'b1;
            end else if (is_brk) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    // ---- stage p1: FIFO write ----
    ps2_scan_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_evt (push_evt),
        .pop      (pop),
        .head_evt (head_evt),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .drop     (fifo_drop)
    );

    // Sticky error flags; a new error in the same cycle beats the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (fifo_drop)    overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (frame_bad)    frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
        end
    end

    // Head fields are masked while empty so stale storage never leaks onto the bus.
    assign key_valid = ~fifo_empty;
    assign key_code  = key_valid ? head_evt.code : 8'h00;
    assign key_ext   = key_valid & head_evt.ext;
    assign key_break = key_valid & head_evt.brk;

endmodule

// File: tb/tb_ps2_scan_buffer.sv
// Directed bench: two receivers share the PS/2 lines, one filtering releases
// and one queueing them.
module tb_ps2_scan_buffer;

    localparam int DEPTH = 8;
    localparam int TOUT  = 300;
    localparam int H     = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       pop;
    logic       clr_err;

    logic       kv_f, ext_f, brk_f, ovf_f, ferr_f;
    logic [7:0] code_f;
    logic [3:0] cnt_f;
    logic       kv_n, ext_n, brk_n, ovf_n, ferr_n;
    logic [7:0] code_n;
    logic [3:0] cnt_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ps2_scan_buffer #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .FILTER_BREAK(1), .TIMEOUT_CYCLES(TOUT)) dut_f (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .pop(pop), .clr_err(clr_err),
        .key_valid(kv_f), .key_code(code_f), .key_ext(ext_f), .key_break(brk_f),
        .fifo_count(cnt_f), .overflow(ovf_f), .frame_err(ferr_f));

    ps2_scan_buffer #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .FILTER_BREAK(0), .TIMEOUT_CYCLES(TOUT)) dut_n (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .pop(pop), .clr_err(clr_err),
        .key_valid(kv_n), .key_code(code_n), .key_ext(ext_n), .key_break(brk_n),
        .fifo_count(cnt_n), .overflow(ovf_n), .frame_err(ferr_n));

    task automatic send_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Full frame; lat reports on which negedge after the stop-bit fall key_valid was first seen.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_on_write, output int lat);
        lat = -1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        @(negedge clk) ps2_data = 1'b1;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        for (int k = 1; k <= H; k++) begin
            @(negedge clk);
            if (lat < 0 && kv_f) lat = k;
            if (pop_on_write) begin
                if (k == 3)      pop = 1'b1;
                else if (k == 4) pop = 1'b0;
            end
        end
        ps2_clk = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk) pop = 1'b1;
        @(negedge clk) pop = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; pop = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({kv_f, code_f, ext_f, brk_f, cnt_f, ovf_f, ferr_f} !== 17'd0) begin errors++; $display("FAIL reset_outputs got=%0h exp=0", {kv_f, code_f, ext_f, brk_f, cnt_f, ovf_f, ferr_f}); end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (kv_f !== 1'b0 || ferr_f !== 1'b0) begin errors++; $display("FAIL after_release got kv=%0b ferr=%0b exp 0 0", kv_f, ferr_f); end
    endtask

    task automatic test_single();
        int lat;
        send_frame(8'h1C, 1'b0, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL latency got=%0d exp=4", lat); end
        checks++; if (kv_f !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", kv_f); end
        checks++; if (code_f !== 8'h1C) begin errors++; $display("FAIL single_code got=%0h exp=1c", code_f); end
        checks++; if ({ext_f, brk_f} !== 2'b00) begin errors++; $display("FAIL single_flags got=%0b exp=00", {ext_f, brk_f}); end
        checks++; if (cnt_f !== 4'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", cnt_f); end
        pop_one();
        checks++; if (kv_f !== 1'b0 || cnt_f !== 4'd0) begin errors++; $display("FAIL single_pop got kv=%0b cnt=%0d exp 0 0", kv_f, cnt_f); end
    endtask

    task automatic test_break();
        int lat;
        send_frame(8'hE0, 1'b0, 1'b0, lat);
        send_frame(8'hF0, 1'b0, 1'b0, lat);
        send_frame(8'h75, 1'b0, 1'b0, lat);
        checks++; if (cnt_n !== 4'd1 || code_n !== 8'h75) begin errors++; $display("FAIL brk_queued got cnt=%0d code=%0h exp 1 75", cnt_n, code_n); end
        checks++; if ({ext_n, brk_n} !== 2'b11) begin errors++; $display("FAIL brk_queued_flags got=%0b exp=11", {ext_n, brk_n}); end
        checks++; if (kv_f !== 1'b0 || cnt_f !== 4'd0) begin errors++; $display("FAIL brk_filtered got kv=%0b cnt=%0d exp 0 0", kv_f, cnt_f); end
        pop_one();
        checks++; if (kv_n !== 1'b0) begin errors++; $display("FAIL brk_pop got=%0b exp=0", kv_n); end
    endtask

    task automatic test_parity();
        int lat;
        checks++; if (ferr_f !== 1'b0) begin errors++; $display("FAIL ferr_clean got=%0b exp=0", ferr_f); end
        send_frame(8'h1C, 1'b1, 1'b0, lat);
        checks++; if (kv_f !== 1'b0) begin errors++; $display("FAIL parity_no_entry got=%0b exp=0", kv_f); end
        checks++; if (ferr_f !== 1'b1) begin errors++; $display("FAIL parity_ferr got=%0b exp=1", ferr_f); end
        pulse_clr();
        checks++; if (ferr_f !== 1'b0) begin errors++; $display("FAIL clr_err got=%0b exp=0", ferr_f); end
    endtask

    task automatic test_overflow_and_full();
        int lat;
        logic [7:0] codes [9];
        logic [7:0] order [8];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        order = '{8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h4D};
        for (int i = 0; i < 9; i++) send_frame(codes[i], 1'b0, 1'b0, lat);
        checks++; if (cnt_f !== 4'd8) begin errors++; $display("FAIL ovf_count got=%0d exp=8", cnt_f); end
        checks++; if (ovf_f !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", ovf_f); end
        checks++; if (code_f !== 8'h15) begin errors++; $display("FAIL ovf_head got=%0h exp=15", code_f); end
        pulse_clr();
        checks++; if (ovf_f !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%0b exp=0", ovf_f); end
        send_frame(8'h4D, 1'b0, 1'b1, lat);
        checks++; if (cnt_f !== 4'd8) begin errors++; $display("FAIL full_pushpop_count got=%0d exp=8", cnt_f); end
        checks++; if (ovf_f !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf got=%0b exp=0", ovf_f); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (kv_f !== 1'b1 || code_f !== order[i]) begin errors++; $display("FAIL drain_%0d got kv=%0b code=%0h exp 1 %0h", i, kv_f, code_f, order[i]); end
            pop_one();
        end
        checks++; if (kv_f !== 1'b0 || cnt_f !== 4'd0) begin errors++; $display("FAIL drain_empty got kv=%0b cnt=%0d exp 0 0", kv_f, cnt_f); end
        pop_one();
        checks++; if (cnt_f !== 4'd0) begin errors++; $display("FAIL pop_empty got=%0d exp=0", cnt_f); end
    endtask

    task automatic test_timeout();
        int lat;
        pulse_clr();
        for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
        repeat (TOUT - 3*H) @(negedge clk);
        checks++; if (ferr_f !== 1'b0) begin errors++; $display("FAIL timeout_early got=%0b exp=0", ferr_f); end
        repeat (3*H) @(negedge clk);
        checks++; if (ferr_f !== 1'b1) begin errors++; $display("FAIL timeout_ferr got=%0b exp=1", ferr_f); end
        send_frame(8'h29, 1'b0, 1'b0, lat);
        checks++; if (kv_f !== 1'b1 || code_f !== 8'h29 || ext_f !== 1'b0) begin errors++; $display("FAIL after_timeout got kv=%0b code=%0h ext=%0b exp 1 29 0", kv_f, code_f, ext_f); end
        checks++; if (ferr_f !== 1'b1) begin errors++; $display("FAIL ferr_sticky got=%0b exp=1", ferr_f); end
    endtask

    task automatic test_reset_mid();
        int lat;
        send_frame(8'hE0, 1'b0, 1'b0, lat);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        checks++; if (kv_f !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%0b exp=1", kv_f); end
        @(negedge clk) rst = 1'b0;
        #1;
        checks++; if ({kv_f, code_f, ext_f, brk_f, cnt_f, ovf_f, ferr_f} !== 17'd0) begin errors++; $display("FAIL midreset_f got=%0h exp=0", {kv_f, code_f, ext_f, brk_f, cnt_f, ovf_f, ferr_f}); end
        checks++; if ({kv_n, code_n, ext_n, brk_n, cnt_n, ovf_n, ferr_n} !== 17'd0) begin errors++; $display("FAIL midreset_n got=%0h exp=0", {kv_n, code_n, ext_n, brk_n, cnt_n, ovf_n, ferr_n}); end
        ps2_data = 1'b1;
        @(negedge clk) rst = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b0, lat);
        checks++; if (kv_f !== 1'b1 || code_f !== 8'h1C || cnt_f !== 4'd1) begin errors++; $display("FAIL post_reset got kv=%0b code=%0h cnt=%0d exp 1 1c 1", kv_f, code_f, cnt_f); end
        checks++; if (ext_f !== 1'b0 || ferr_f !== 1'b0) begin errors++; $display("FAIL post_reset_flags got ext=%0b ferr=%0b exp 0 0", ext_f, ferr_f); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_break();
        test_parity();
        test_overflow_and_full();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
